csel_pipe_adder: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshaking. Each pipeline stage resolves one BLOCK_W-bit slice using a precomputed carry-0/carry-1 pair and a select mux. A WIDTH-bit operation completes in WIDTH/BLOCK_W cycles at one result per cycle. It replaces the fixed 64-bit combinational adder in the datapath wherever timing requires a registered and back-pressurable adder.

---
 rtl/adder_pkg.sv | 14 +
 rtl/csel_pipe_adder_slice.sv | 52 +++++
 rtl/csel_pipe_adder.sv | 169 ++++++++++++++++
 tb/tb_csel_pipe_adder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-select adder family:
// stage-count helper and the add/subtract op-mode encoding.
package adder_pkg;

   // Operation select values seen on sub_i.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Number of pipeline stages (one BLOCK_W slice resolved per stage).
   function automatic int nstage(input int width, input int block_w);
      return width / block_w;
   endfunction

endpackage

// File: rtl/csel_pipe_adder_slice.sv
// One carry-select slice: two ripple chains (carry-in 0 and carry-in 1)
// computed in parallel, then a 2:1 mux driven by the incoming carry.
// cmsb_o is the carry into the slice MSB, needed for signed overflow.
module csel_slice #(
   parameter int BLOCK_W = 16
) (
   input  logic [BLOCK_W-1:0] a_i,
   input  logic [BLOCK_W-1:0] b_i,
   input  logic               cin_sel_i,
   output logic [BLOCK_W-1:0] sum_o,
   output logic               cout_o,
   output logic               cmsb_o
);

   logic [BLOCK_W:0]   c0_s;
   logic [BLOCK_W:0]   c1_s;
   logic [BLOCK_W-1:0] s0_s;
   logic [BLOCK_W-1:0] s1_s;

   // Both speculative ripple chains, one assuming carry-in 0, one carry-in 1.
   always_comb begin
      c0_s    = '0;
      c1_s    = '0;
      s0_s    = '0;
      s1_s    = '0;
      c0_s[0] = 1'b0;
      c1_s[0] = 1'b1;
      for (int i = 0; i < BLOCK_W; i++) begin
         s0_s[i]   = a_i[i] ^ b_i[i] ^ c0_s[i];
         c0_s[i+1] = (a_i[i] & b_i[i]) | (c0_s[i] & (a_i[i] ^ b_i[i]));
         s1_s[i]   = a_i[i] ^ b_i[i] ^ c1_s[i];
         c1_s[i+1] = (a_i[i] & b_i[i]) | (c1_s[i] & (a_i[i] ^ b_i[i]));
      end
   end

   // Select the precomputed result matching the real carry-in.
   always_comb begin
      sum_o  = '0;
      cout_o = 1'b0;
      cmsb_o = 1'b0;
      if (cin_sel_i) begin
         sum_o  = s1_s;
         cout_o = c1_s[BLOCK_W];
         cmsb_o = c1_s[BLOCK_W-1];
      end else begin
         sum_o  = s0_s;
         cout_o = c0_s[BLOCK_W];
         cmsb_o = c0_s[BLOCK_W-1];
      end
   end

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor. Stage k resolves bits
// [k*BLOCK_W +: BLOCK_W]; operand bits not yet consumed and sum bits
// already resolved travel alongside. A single global stall (adv) freezes
// every stage when the output holds a result the consumer refuses.
module csel_pipe_adder
   import adder_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int BLOCK_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             cin_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int NSTAGE = nstage(WIDTH, BLOCK_W);

   // Reject configurations that cannot be split into whole slices.
   generate
      if ((BLOCK_W < 1) || (WIDTH % BLOCK_W != 0) || (NSTAGE < 1)) begin : g_bad_cfg
         $error("csel_pipe_adder: WIDTH must be a non-zero multiple of BLOCK_W");
      end
   endgenerate

   // Global advance and stage-0 operand transform.
   logic             adv_s;
   logic [WIDTH-1:0] b_eff_s;
   logic             c0_s;

   // Per-stage inputs (from the ports for stage 0, from the previous stage otherwise).
   logic [WIDTH-1:0] in_a_s   [NSTAGE];
   logic [WIDTH-1:0] in_b_s   [NSTAGE];
   logic [WIDTH-1:0] in_sum_s [NSTAGE];
   logic [NSTAGE-1:0] in_c_s;

   // Slice results.
   logic [NSTAGE-1:0][BLOCK_W-1:0] sl_sum_s;
   logic [NSTAGE-1:0]              sl_cout_s;
   logic [NSTAGE-1:0]              sl_cmsb_s;

   // Stage registers and their next-state values.
   logic [WIDTH-1:0]  a_q   [NSTAGE];
   logic [WIDTH-1:0]  b_q   [NSTAGE];
   logic [WIDTH-1:0]  sum_q [NSTAGE];
   logic [WIDTH-1:0]  a_d   [NSTAGE];
   logic [WIDTH-1:0]  b_d   [NSTAGE];
   logic [WIDTH-1:0]  sum_d [NSTAGE];
   logic [NSTAGE-1:0] carry_q;
   logic [NSTAGE-1:0] carry_d;
   logic [NSTAGE-1:0] valid_q;
   logic [NSTAGE-1:0] valid_d;
   logic              ovf_q;
   logic              ovf_d;

   // Operand bits below a slice are dead once resolved; gather them in one sink.
   logic unused_s;

   // Pipeline advances unless a finished result is waiting on the consumer.
   assign adv_s   = !valid_q[NSTAGE-1] || ready_i;
   assign ready_o = adv_s;
   assign valid_o = valid_q[NSTAGE-1];
   assign sum_o   = sum_q[NSTAGE-1];
   assign cout_o  = carry_q[NSTAGE-1];
   assign ovf_o   = ovf_q;

   // Subtraction is A + ~B + ~borrow; cin_i doubles as borrow-in.
   always_comb begin
      b_eff_s = b_i;
      c0_s    = cin_i;
      if (sub_i == OP_SUB) begin
         b_eff_s = ~b_i;
         c0_s    = ~cin_i;
      end else begin
         b_eff_s = b_i;
         c0_s    = cin_i;
      end
   end

   // Route each stage's inputs from the ports or from the preceding stage.
   always_comb begin
      in_c_s      = '0;
      in_a_s[0]   = a_i;
      in_b_s[0]   = b_eff_s;
      in_sum_s[0] = '0;
      in_c_s[0]   = c0_s;
      for (int k = 1; k < NSTAGE; k++) begin
         in_a_s[k]   = a_q[k-1];
         in_b_s[k]   = b_q[k-1];
         in_sum_s[k] = sum_q[k-1];
         in_c_s[k]   = carry_q[k-1];
      end
   end

   // One carry-select slice per stage.
   generate
      for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
         csel_slice #(
            .BLOCK_W (BLOCK_W)
         ) u_slice (
            .a_i       (in_a_s[k][k*BLOCK_W +: BLOCK_W]),
            .b_i       (in_b_s[k][k*BLOCK_W +: BLOCK_W]),
            .cin_sel_i (in_c_s[k]),
            .sum_o     (sl_sum_s[k]),
            .cout_o    (sl_cout_s[k]),
            .cmsb_o    (sl_cmsb_s[k])
         );
      end
   endgenerate

   // Next-state: splice the freshly resolved slice into the travelling sum.
   always_comb begin
      valid_d    = '0;
      carry_d    = '0;
      valid_d[0] = valid_i && adv_s;
      ovf_d      = sl_cmsb_s[NSTAGE-1] ^ sl_cout_s[NSTAGE-1];
      for (int k = 0; k < NSTAGE; k++) begin
         a_d[k]                         = in_a_s[k];
         b_d[k]                         = in_b_s[k];
         sum_d[k]                       = in_sum_s[k];
         sum_d[k][k*BLOCK_W +: BLOCK_W] = sl_sum_s[k];
         carry_d[k]                     = sl_cout_s[k];
      end
      for (int k = 1; k < NSTAGE; k++) begin
         valid_d[k] = valid_q[k-1];
      end
   end

   // Stage registers: reset clears everything, otherwise load on advance and hold on stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (adv_s) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   // Fold consumed operand bits together so they have a single reader.
   always_comb begin
      unused_s = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
         unused_s = unused_s ^ (^a_q[k]) ^ (^b_q[k]);
      end
   end

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Bench for csel_pipe_adder: a 64/16 instance and an 8/8 instance, fixed
// vectors, stall/reset sequences and randomized traffic scored against an
// arithmetic reference model.
module tb_csel_pipe_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        v64_i, r64_o, v64_o, rdy64_i, sub64, cin64, cout64, ovf64;
   logic [63:0] a64, b64, s64;
   logic        v8_i, r8_o, v8_o, rdy8_i, sub8, cin8, cout8, ovf8;
   logic [7:0]  a8, b8, s8;

   csel_pipe_adder #(.WIDTH(64), .BLOCK_W(16)) dut64 (
      .clk_i(clk), .rst_i(rst), .valid_i(v64_i), .ready_o(r64_o),
      .a_i(a64), .b_i(b64), .sub_i(sub64), .cin_i(cin64),
      .valid_o(v64_o), .ready_i(rdy64_i), .sum_o(s64), .cout_o(cout64), .ovf_o(ovf64));

   csel_pipe_adder #(.WIDTH(8), .BLOCK_W(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .valid_i(v8_i), .ready_o(r8_o),
      .a_i(a8), .b_i(b8), .sub_i(sub8), .cin_i(cin8),
      .valid_o(v8_o), .ready_i(rdy8_i), .sum_o(s8), .cout_o(cout8), .ovf_o(ovf8));

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic        cin;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   res_t q64[$];
   res_t q8[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic signed [71:0] sx(input logic [71:0] u, input int w);
      if (u[w-1]) return $signed(u - (72'd1 << w));
      else        return $signed(u);
   endfunction

   // Reference: unsigned result/carry from plain arithmetic, overflow from signed range.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic sub, input logic cin, input int w);
      logic [71:0]        mask, ua, ub, tot;
      logic signed [71:0] sa, sb, sc, sr, smax, smin;
      res_t r;
      mask = (72'd1 << w) - 72'd1;
      ua   = {8'h00, a} & mask;
      ub   = {8'h00, b} & mask;
      sa   = sx(ua, w);
      sb   = sx(ub, w);
      sc   = {71'd0, cin};
      if (!sub) begin
         tot    = ua + ub + {71'd0, cin};
         r.cout = tot[w];
         sr     = sa + sb + sc;
      end else begin
         tot    = ua - ub - {71'd0, cin};
         r.cout = (ua >= ub + {71'd0, cin});
         sr     = sa - sb - sc;
      end
      r.sum = 64'(tot & mask);
      smax  = (72'sd1 <<< (w - 1)) - 72'sd1;
      smin  = -(72'sd1 <<< (w - 1));
      r.ovf = (sr > smax) || (sr < smin);
      return r;
   endfunction

   // Scoreboard for the 64-bit instance.
   logic        pst64 = 1'b0;
   logic [63:0] ps64;
   always @(negedge clk) begin : mon64
      res_t e;
      if (rst) begin
         q64.delete();
         pst64 = 1'b0;
      end else begin
         chk("ready_rule64", {63'd0, r64_o}, {63'd0, (!v64_o || rdy64_i)});
         if (pst64) chk("stall_hold64", s64, ps64);
         if (v64_o && rdy64_i) begin
            if (q64.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected64: got result %h expected no result", s64);
            end else begin
               e = q64.pop_front();
               chk("sum64", s64, e.sum);
               chk("cout64", {63'd0, cout64}, {63'd0, e.cout});
               chk("ovf64", {63'd0, ovf64}, {63'd0, e.ovf});
            end
         end
         if (v64_i && r64_o) q64.push_back(model(a64, b64, sub64, cin64, 64));
         pst64 = v64_o && !rdy64_i;
         ps64  = s64;
      end
   end

   // Scoreboard for the 8-bit instance.
   logic       pst8 = 1'b0;
   logic [7:0] ps8;
   always @(negedge clk) begin : mon8
      res_t e;
      if (rst) begin
         q8.delete();
         pst8 = 1'b0;
      end else begin
         chk("ready_rule8", {63'd0, r8_o}, {63'd0, (!v8_o || rdy8_i)});
         if (pst8) chk("stall_hold8", {56'd0, s8}, {56'd0, ps8});
         if (v8_o && rdy8_i) begin
            if (q8.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected8: got result %h expected no result", s8);
            end else begin
               e = q8.pop_front();
               chk("sum8", {56'd0, s8}, e.sum);
               chk("cout8", {63'd0, cout8}, {63'd0, e.cout});
               chk("ovf8", {63'd0, ovf8}, {63'd0, e.ovf});
            end
         end
         if (v8_i && r8_o) q8.push_back(model({56'd0, a8}, {56'd0, b8}, sub8, cin8, 8));
         pst8 = v8_o && !rdy8_i;
         ps8  = s8;
      end
   end

   // Single 64-bit operation with exact latency check (valid after edge t+3).
   task automatic run_vec64(input vec_t v);
      @(posedge clk); #2;
      v64_i = 1'b1; a64 = v.a; b64 = v.b; sub64 = v.sub; cin64 = v.cin;
      @(posedge clk); #2;
      v64_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("lat_early64", {63'd0, v64_o}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_valid64", {63'd0, v64_o}, 64'd1);
      chk("vec_sum64", s64, v.sum);
      chk("vec_cout64", {63'd0, cout64}, {63'd0, v.cout});
      chk("vec_ovf64", {63'd0, ovf64}, {63'd0, v.ovf});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[6];
      logic [63:0] got[$];
      int          rc[$];
      int          exp_rc[8];
      int          i;
      int          acc64;
      int          acc8;

      rst = 1'b1;
      v64_i = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; cin64 = 1'b0; rdy64_i = 1'b1;
      v8_i  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0; cin8  = 1'b0; rdy8_i  = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid64", {63'd0, v64_o}, 64'd0);
      chk("rst_sum64", s64, 64'd0);
      chk("rst_cout64", {63'd0, cout64}, 64'd0);
      chk("rst_ovf64", {63'd0, ovf64}, 64'd0);
      chk("rst_ready64", {63'd0, r64_o}, 64'd1);
      chk("rst_valid8", {63'd0, v8_o}, 64'd0);
      chk("rst_ready8", {63'd0, r8_o}, 64'd1);

      vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[1] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[3] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 1'b1, 64'h0000_FFFF_0001_0001, 1'b0, 1'b0};
      vecs[4] = '{64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      for (int k = 0; k < 6; k++) run_vec64(vecs[k]);

      // 8-bit instance: single stage, latency 1.
      @(posedge clk); #2;
      v8_i = 1'b1; a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; cin8 = 1'b0;
      @(posedge clk); #2;
      v8_i = 1'b0;
      @(negedge clk);
      chk("n1_valid8", {63'd0, v8_o}, 64'd1);
      chk("n1_sum8", {56'd0, s8}, 64'd0);
      chk("n1_cout8", {63'd0, cout8}, 64'd1);
      chk("n1_ovf8", {63'd0, ovf8}, 64'd1);

      // Stream of 8 with a 3-cycle consumer stall.
      exp_rc = '{4, 5, 9, 10, 11, 12, 13, 14};
      i = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(posedge clk); #2;
         rdy64_i = !(cyc >= 6 && cyc <= 8);
         if (i < 8) begin
            v64_i = 1'b1; a64 = 64'(i); b64 = 64'(3 * i); sub64 = 1'b0; cin64 = 1'b0;
         end else begin
            v64_i = 1'b0;
         end
         @(negedge clk);
         if (!rdy64_i && v64_o) chk("stall_ready64", {63'd0, r64_o}, 64'd0);
         if (v64_o && rdy64_i) begin
            got.push_back(s64);
            rc.push_back(cyc);
         end
         if (v64_i && r64_o) i++;
      end
      rdy64_i = 1'b1;
      chk("stream_count", 64'(got.size()), 64'd8);
      if (got.size() == 8) begin
         for (int j = 0; j < 8; j++) begin
            chk("stream_sum", got[j], 64'(4 * j));
            chk("stream_cycle", 64'(rc[j]), 64'(exp_rc[j]));
         end
      end

      // Reset with two operations in flight.
      @(posedge clk); #2;
      v64_i = 1'b1; a64 = 64'd11; b64 = 64'd22; sub64 = 1'b0; cin64 = 1'b0;
      @(posedge clk); #2;
      a64 = 64'd33; b64 = 64'd44;
      @(posedge clk); #2;
      v64_i = 1'b0; rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("inrst_sum64", s64, 64'd0);
      chk("inrst_cout64", {63'd0, cout64}, 64'd0);
      chk("inrst_ovf64", {63'd0, ovf64}, 64'd0);
      chk("inrst_ready64", {63'd0, r64_o}, 64'd1);
      for (int n = 0; n < 6; n++) begin
         chk("inrst_valid64", {63'd0, v64_o}, 64'd0);
         @(negedge clk);
      end

      // Randomized traffic on both instances.
      acc64 = 0;
      acc8  = 0;
      for (int cyc = 0; cyc < 40000 && (acc64 < 2000 || acc8 < 10000); cyc++) begin
         @(posedge clk); #2;
         v64_i   = (acc64 < 2000) && ($urandom_range(3) != 0);
         a64     = {$urandom, $urandom};
         b64     = {$urandom, $urandom};
         if ($urandom_range(7) == 0) b64 = ~a64;
         sub64   = 1'($urandom_range(1));
         cin64   = 1'($urandom_range(1));
         rdy64_i = ($urandom_range(3) != 0);
         v8_i    = (acc8 < 10000) && ($urandom_range(3) != 0);
         a8      = 8'($urandom);
         b8      = 8'($urandom);
         sub8    = 1'($urandom_range(1));
         cin8    = 1'($urandom_range(1));
         rdy8_i  = ($urandom_range(3) != 0);
         @(negedge clk);
         if (v64_i && r64_o) acc64++;
         if (v8_i && r8_o) acc8++;
      end
      chk("rand_acc64", 64'(acc64), 64'd2000);
      chk("rand_acc8", 64'(acc8), 64'd10000);

      @(posedge clk); #2;
      v64_i = 1'b0; v8_i = 1'b0; rdy64_i = 1'b1; rdy8_i = 1'b1;
      for (int n = 0; n < 20 && (q64.size() != 0 || q8.size() != 0); n++) @(negedge clk);
      chk("drain64", 64'(q64.size()), 64'd0);
      chk("drain8", 64'(q8.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
